// File: rtl/ped_request_unit_pkg.sv
// Shared types and constants for the pedestrian request unit.
// Holds the FSM state encoding, the default timing constants, the display
// and statistics widths, and a saturating increment helper.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        SERVING  = 2'b10,
        COOLDOWN = 2'b11
    } ped_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_CROSSING_TIME   = 15;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 8;

    localparam int unsigned CD_W   = 5;
    localparam int unsigned WAIT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == {WAIT_W{1'b1}}) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/ped_request_unit_if.sv
// Kerb-side / controller signal bundle of the pedestrian request unit.
//   button_raw         raw push-button level (1 = pressed)
//   pedestrian_light   controller walk signal (1 = crossing granted)
//   pedestrian_request held request to the controller
//   wait_lamp          "WAIT" indicator
//   walk_countdown     remaining walk time, 0 when not serving
//   last_wait          request-to-grant cycles of the last served request
// master drives the button and light; slave is the request unit.
interface ped_request_unit_if;
    import ped_pkg::*;

    logic              button_raw;
    logic              pedestrian_light;
    logic              pedestrian_request;
    logic              wait_lamp;
    logic [CD_W-1:0]   walk_countdown;
    logic [WAIT_W-1:0] last_wait;

    modport master (
        output button_raw,
        output pedestrian_light,
        input  pedestrian_request,
        input  wait_lamp,
        input  walk_countdown,
        input  last_wait
    );

    modport slave (
        input  button_raw,
        input  pedestrian_light,
        output pedestrian_request,
        output wait_lamp,
        output walk_countdown,
        output last_wait
    );

endinterface

// File: rtl/ped_button_debounce.sv
// Button input path: two-flop synchroniser, level debouncer and press pulse.
//   clk, reset    clock, asynchronous active-high reset
//   button_raw_i  asynchronous bouncing button level
//   press_c       high for the cycle in which the debounced level is about
//                 to rise 0->1 (decoded from registered state only)
module ped_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = ped_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw_i,
    output logic press_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ_c;
    logic             accept_c;

    assign differ_c = (sync2_q != db_level_q);
    // Enough consecutive differing samples: the new level is taken this edge.
    assign accept_c = differ_c && (cnt_q == CNT_LAST);
    assign press_c  = accept_c && sync2_q;

    // Synchroniser and debounce counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q <= button_raw_i;
            sync2_q <= sync1_q;
            if (!differ_c) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                db_level_q <= sync2_q;
                cnt_q      <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end for the traffic light controller.
// Debounces the button, holds a request until the controller grants the
// crossing, drives the WAIT lamp and walk countdown, and enforces a cooldown
// after each crossing.
//   clk, reset  clock, asynchronous active-high reset
//   bus         ped_request_unit_if.slave (button, light, request, lamp,
//               countdown, last_wait)
// Optional feature macro PED_WAIT_STATS_EN: when defined, last_wait reports
// the request-to-grant cycle count of the last served request (saturating at
// 255); when undefined last_wait is tied to 0.
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CROSSING_TIME   = DEF_CROSSING_TIME,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    ped_request_unit_if.slave  bus
);

    localparam int unsigned COOL_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(CROSSING_TIME);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);

    ped_state_e        state_q;
    logic              pending_q;
    logic              req_q;
    logic [CD_W-1:0]   countdown_q;
    logic [COOL_W-1:0] cool_q;
    logic              press_c;
    logic              light;

    assign light = bus.pedestrian_light;

    ped_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .button_raw_i (bus.button_raw),
        .press_c      (press_c)
    );

    // Request FSM with registered request and countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            req_q       <= 1'b0;
            countdown_q <= '0;
            cool_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // An unsolicited grant takes priority over a coincident press.
                    if (light) begin
                        state_q     <= SERVING;
                        countdown_q <= CD_LOAD;
                    end else if (press_c) begin
                        state_q <= ARMED;
                        req_q   <= 1'b1;
                    end
                end
                ARMED: begin
                    // Presses here are dropped, including one coincident with the grant.
                    if (light) begin
                        state_q     <= SERVING;
                        req_q       <= 1'b0;
                        countdown_q <= CD_LOAD;
                    end
                end
                SERVING: begin
                    if (!light) begin
                        state_q     <= COOLDOWN;
                        countdown_q <= '0;
                        cool_q      <= COOL_LOAD;
                    end else if (countdown_q != '0) begin
                        countdown_q <= countdown_q - CD_W'(1);
                    end
                    if (press_c) begin
                        pending_q <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    // A press in the last cooldown cycle still counts.
                    if (cool_q == '0) begin
                        pending_q <= 1'b0;
                        if (pending_q || press_c) begin
                            state_q <= ARMED;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cool_q <= cool_q - COOL_W'(1);
                        if (press_c) begin
                            pending_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pedestrian_request = req_q;
    assign bus.wait_lamp          = req_q;
    assign bus.walk_countdown     = countdown_q;

`ifdef PED_WAIT_STATS_EN
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] last_wait_q;

    // Wait counter rests at 0 outside ARMED, so it starts from 0 on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q      <= '0;
            last_wait_q <= '0;
        end else begin
            if (state_q == ARMED) begin
                wait_q <= sat_inc_wait(wait_q);
            end else begin
                wait_q <= '0;
            end
            // The grant cycle itself is still an ARMED cycle.
            if ((state_q == ARMED) && light) begin
                last_wait_q <= sat_inc_wait(wait_q);
            end
        end
    end

    assign bus.last_wait = last_wait_q;
`else
    assign bus.last_wait = '0;
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// Self-checking bench for ped_request_unit: directed stimulus pushes
// cycle-stamped expectations into a scoreboard, a negedge monitor pops and
// compares them against the DUT outputs.
module tb_ped_request_unit;

`ifdef PED_WAIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        string       name;
        logic        req;
        logic [4:0]  cd;
        logic        chk_lw;
        logic [7:0]  lw;
    } exp_t;

    logic clk;
    logic reset;
    int unsigned cyc = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    bit draining = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    int unsigned k, g, h, b, p1, q, u, r, a, p2;

    ped_request_unit_if bus ();

    ped_request_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int unsigned c);
        while (cyc < c) tick(1);
    endtask

    // Insert keeping the scoreboard ordered by due cycle.
    task automatic expect_full(input int unsigned c, input string n, input logic rq,
                               input logic [4:0] cd, input logic chk, input logic [7:0] lw);
        exp_t e;
        int i;
        e.cyc = c; e.name = n; e.req = rq; e.cd = cd; e.chk_lw = chk; e.lw = lw;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].cyc > c) i--;
        sb_q.insert(i, e);
    endtask

    task automatic expect_at(input int unsigned c, input string n, input logic rq,
                             input logic [4:0] cd);
        expect_full(c, n, rq, cd, 1'b0, 8'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (mon_e.cyc != cyc ||
                bus.pedestrian_request !== mon_e.req ||
                bus.wait_lamp !== mon_e.req ||
                bus.walk_countdown !== mon_e.cd ||
                (mon_e.chk_lw && bus.last_wait !== mon_e.lw)) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): got req=%b lamp=%b cd=%0d lw=%0d, want req=%b lamp=%b cd=%0d lw=%0d",
                         mon_e.name, cyc, mon_e.cyc, bus.pedestrian_request, bus.wait_lamp,
                         bus.walk_countdown, bus.last_wait, mon_e.req, mon_e.req, mon_e.cd, mon_e.lw);
            end
        end
        if (draining) begin
            while (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL %s: never checked, due cyc %0d, now %0d", mon_e.name, mon_e.cyc, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.button_raw = 1'b0;
        bus.pedestrian_light = 1'b0;
        tick(3);
        reset = 1'b0;
        expect_full(cyc, "reset", 1'b0, 5'd0, 1'b1, 8'd0);
        tick(2);

        // Clean press held 10 cycles.
        k = cyc;
        expect_at(k + 5, "press_pre", 1'b0, 5'd0);
        expect_at(k + 6, "press", 1'b1, 5'd0);
        expect_at(k + 15, "armed_hold", 1'b1, 5'd0);
        bus.button_raw = 1'b1;
        tick(10);
        bus.button_raw = 1'b0;
        tick(8);

        // Grant for 18 cycles with a press during SERVING.
        g = cyc;
        expect_at(g + 1, "grant", 1'b0, 5'd15);
        expect_at(g + 2, "cd14", 1'b0, 5'd14);
        expect_at(g + 9, "cd7", 1'b0, 5'd7);
        expect_at(g + 16, "cd0", 1'b0, 5'd0);
        expect_at(g + 18, "cd_sat", 1'b0, 5'd0);
        expect_at(g + 19, "cool_entry", 1'b0, 5'd0);
        expect_at(g + 26, "cool_last", 1'b0, 5'd0);
        expect_at(g + 27, "relatch", 1'b1, 5'd0);
        expect_at(g + 29, "relatch_hold", 1'b1, 5'd0);
        bus.pedestrian_light = 1'b1;
        tick(2);
        bus.button_raw = 1'b1;
        tick(8);
        bus.button_raw = 1'b0;
        tick(8);
        bus.pedestrian_light = 1'b0;
        tick_to(g + 30);

        // Short grant, no press: cooldown then idle.
        h = cyc;
        expect_at(h + 1, "g2", 1'b0, 5'd15);
        expect_at(h + 3, "g2_cd13", 1'b0, 5'd13);
        expect_at(h + 4, "g2_cool", 1'b0, 5'd0);
        expect_at(h + 12, "g2_idle", 1'b0, 5'd0);
        expect_at(h + 20, "g2_idle_hold", 1'b0, 5'd0);
        bus.pedestrian_light = 1'b1;
        tick(3);
        bus.pedestrian_light = 1'b0;
        tick_to(h + 22);

        // Bounce 1,0,1,0 on single cycles.
        b = cyc;
        expect_at(b + 3, "bounce_a", 1'b0, 5'd0);
        expect_at(b + 7, "bounce_b", 1'b0, 5'd0);
        expect_at(b + 12, "bounce_c", 1'b0, 5'd0);
        bus.button_raw = 1'b1; tick(1);
        bus.button_raw = 1'b0; tick(1);
        bus.button_raw = 1'b1; tick(1);
        bus.button_raw = 1'b0;
        tick_to(b + 14);

        // Arm, release, then a new press coincident with the grant.
        p1 = cyc;
        expect_at(p1 + 6, "rearm", 1'b1, 5'd0);
        bus.button_raw = 1'b1;
        tick(8);
        bus.button_raw = 1'b0;
        tick(8);
        q = cyc;
        expect_at(q + 5, "simul_pre", 1'b1, 5'd0);
        expect_at(q + 6, "simul_grant", 1'b0, 5'd15);
        expect_at(q + 7, "simul_cd14", 1'b0, 5'd14);
        expect_at(q + 8, "simul_cool", 1'b0, 5'd0);
        expect_at(q + 16, "simul_idle", 1'b0, 5'd0);
        expect_at(q + 22, "simul_idle_hold", 1'b0, 5'd0);
        bus.button_raw = 1'b1;
        tick(5);
        bus.pedestrian_light = 1'b1;
        tick(2);
        bus.pedestrian_light = 1'b0;
        tick(5);
        bus.button_raw = 1'b0;
        tick_to(q + 24);

        // Unsolicited grant from IDLE, press lands in the last cooldown cycle.
        u = cyc;
        expect_at(u + 1, "unsolicited", 1'b0, 5'd15);
        expect_at(u + 9, "late_pre", 1'b0, 5'd0);
        expect_at(u + 10, "late_press", 1'b1, 5'd0);
        expect_at(u + 13, "armed_pre_rst", 1'b1, 5'd0);
        bus.pedestrian_light = 1'b1;
        tick(1);
        bus.pedestrian_light = 1'b0;
        tick(3);
        bus.button_raw = 1'b1;
        tick_to(u + 14);

        // Asynchronous reset mid-ARMED with the button held through release.
        r = cyc;
        expect_full(r, "rst_async", 1'b0, 5'd0, 1'b1, 8'd0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_at(r + 8, "rst_pre", 1'b0, 5'd0);
        expect_at(r + 9, "rst_rearm", 1'b1, 5'd0);
        a = r + 9;

        // Wait statistics: 40-cycle wait, then a saturating 300-cycle wait.
        tick_to(a + 39);
        expect_full(a + 40, "stat40", 1'b0, 5'd15, 1'b1, STATS ? 8'd40 : 8'd0);
        expect_full(a + 41, "stat40_hold", 1'b0, 5'd14, 1'b1, STATS ? 8'd40 : 8'd0);
        expect_at(a + 50, "stat_idle", 1'b0, 5'd0);
        bus.pedestrian_light = 1'b1;
        tick(2);
        bus.pedestrian_light = 1'b0;
        bus.button_raw = 1'b0;
        tick_to(a + 60);
        p2 = cyc;
        expect_at(p2 + 6, "p2_arm", 1'b1, 5'd0);
        expect_full(p2 + 305, "stat_hold", 1'b1, 5'd0, 1'b1, STATS ? 8'd40 : 8'd0);
        expect_full(p2 + 306, "stat255", 1'b0, 5'd15, 1'b1, STATS ? 8'd255 : 8'd0);
        expect_full(p2 + 307, "stat255_cool", 1'b0, 5'd0, 1'b1, STATS ? 8'd255 : 8'd0);
        bus.button_raw = 1'b1;
        tick(8);
        bus.button_raw = 1'b0;
        tick_to(p2 + 305);
        bus.pedestrian_light = 1'b1;
        tick(1);
        bus.pedestrian_light = 1'b0;
        tick(12);

        draining = 1'b1;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
